rx_control: RTL and testbench

- Sequencing controller for the UART receive datapath.
- Detects the start bit on `rx`, times half-bit and full-bit intervals from a programmable baud divisor, and counts received bits.
- Drives `start`, `btu` (bit-time-up) and the one-cycle `done` strobe that the receive datapath uses to shift, check and flag each frame.
- Sits between the baud/config registers and the receive datapath inside the UART receiver.

---
 rtl/rx_control.sv | 139 +++++++++++++
 tb/tb_rx_control.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_control.sv
`default_nettype none
// ============================================================================
//  Module      : rx_control
//  Description : UART receive sequencing controller. Detects the start bit,
//                times half/full bit intervals from baud_k, counts bits and
//                issues start/doit/btu/done to the receive datapath.
//                Optional build macro RX_SYNC_EN adds a 2-flop rx
//                synchronizer and exports the synchronized line on rx_s.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_control #(
    parameter int BAUD_W = 19,
    parameter int BCNT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              eight,
    input  logic              pen,
    output logic              start,
    output logic              doit,
    output logic              btu,
    output logic              done,
    output logic [BCNT_W-1:0] bit_cnt
`ifdef RX_SYNC_EN
    ,
    output logic              rx_s
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    localparam logic [BAUD_W-1:0] C_MIN_K = BAUD_W'(2);

    state_t              r_state;
    logic [BAUD_W-1:0]   r_bt_cnt;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic                r_eight;
    logic                r_pen;
    logic                r_done;

    logic                w_rx;
    logic [BAUD_W-1:0]   w_k;
    logic [BAUD_W-1:0]   w_half;
    logic [BAUD_W-1:0]   w_term;
    logic [BCNT_W-1:0]   w_last_idx;
    logic                w_btu;
    logic                w_last;

`ifdef RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Both stages reset to the idle level so no false start is seen after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;
    assign rx_s = r_sync2;
`else
    assign w_rx = rx;
`endif

    // Divisors below 2 would leave no room for a half-bit interval
    assign w_k        = (baud_k < C_MIN_K) ? C_MIN_K : baud_k;
    assign w_half     = w_k >> 1;
    assign w_term     = (r_state == ST_START) ? w_half : w_k;
    assign w_btu      = (r_state != ST_IDLE) && (r_bt_cnt == (w_term - BAUD_W'(1)));
    assign w_last_idx = BCNT_W'(7) + BCNT_W'(r_eight) + BCNT_W'(r_pen);
    assign w_last     = (r_bit_cnt == w_last_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_bt_cnt  <= '0;
            r_bit_cnt <= '0;
            r_eight   <= 1'b0;
            r_pen     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) begin
                        r_state   <= ST_START;
                        r_bt_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_eight   <= eight;
                        r_pen     <= pen;
                    end
                end
                ST_START: begin
                    if (w_btu) begin
                        r_bt_cnt <= '0;
                        r_state  <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_bt_cnt <= r_bt_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_btu) begin
                        r_bt_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_bt_cnt <= r_bt_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_bt_cnt <= '0;
                end
            endcase
        end
    end

    assign start   = (r_state == ST_START);
    assign doit    = (r_state == ST_START) || (r_state == ST_DATA);
    assign btu     = w_btu;
    assign done    = r_done;
    assign bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_control
//  Description : Self-checking bench for rx_control: frame-level timing model
//                compared every cycle, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rx_control;

    localparam int BAUD_W = 19;
    localparam int BCNT_W = 4;
`ifdef RX_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              rx     = 1'b1;
    logic [BAUD_W-1:0] baud_k = BAUD_W'(16);
    logic              eight  = 1'b0;
    logic              pen    = 1'b0;
    logic              start;
    logic              doit;
    logic              btu;
    logic              done;
    logic [BCNT_W-1:0] bit_cnt;
`ifdef RX_SYNC_EN
    logic              rx_s;
`endif

    int n_vec = 0;
    int n_err = 0;

    rx_control #(.BAUD_W(BAUD_W), .BCNT_W(BCNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .baud_k  (baud_k),
        .eight   (eight),
        .pen     (pen),
        .start   (start),
        .doit    (doit),
        .btu     (btu),
        .done    (done),
        .bit_cnt (bit_cnt)
`ifdef RX_SYNC_EN
        ,
        .rx_s    (rx_s)
`endif
    );

    always #5 clk = ~clk;

    // Frame-level model: position inside a frame is the elapsed cycle count e
    // since detection; every output follows from e, K, H and N arithmetically.
    int m_e    = 0;
    int m_k    = 2;
    int m_h    = 1;
    int m_n    = 9;
    int m_hold = 0;
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    bit m_h1   = 1'b1;
    bit m_h2   = 1'b1;

    function automatic bit m_btu();
        if (!m_act)     return 1'b0;
        if (m_e < m_h)  return (m_e == m_h - 1);
        return (((m_e - m_h) % m_k) == m_k - 1);
    endfunction

    always @(posedge clk or negedge reset) begin : model
        bit r;
        bit b;
        int kk;
        if (!reset) begin
            m_act  <= 1'b0;
            m_e    <= 0;
            m_hold <= 0;
            m_done <= 1'b0;
            m_h1   <= 1'b1;
            m_h2   <= 1'b1;
        end else begin
            r  = SYNC ? m_h2 : rx;
            b  = m_btu();
            kk = (baud_k < BAUD_W'(2)) ? 2 : int'(baud_k);
            m_h1   <= rx;
            m_h2   <= m_h1;
            m_done <= 1'b0;
            if (!m_act) begin
                if (!r) begin
                    m_act  <= 1'b1;
                    m_e    <= 0;
                    m_hold <= 0;
                    m_k    <= kk;
                    m_h    <= kk / 2;
                    m_n    <= 8 + int'(eight) + int'(pen);
                end
            end else if (!b) begin
                m_e <= m_e + 1;
            end else if (m_e < m_h) begin
                if (r) begin
                    m_act  <= 1'b0;
                    m_hold <= 0;
                end else begin
                    m_e <= m_e + 1;
                end
            end else if ((m_e - m_h) / m_k + 1 == m_n) begin
                m_act  <= 1'b0;
                m_hold <= m_n;
                m_done <= 1'b1;
            end else begin
                m_e <= m_e + 1;
            end
        end
    end

    // Pulse tallies used by the directed checks
    int cnt_st = 0;
    int cnt_db = 0;
    int cnt_dn = 0;
    int done_bc = 0;

    task automatic compare_loop();
        logic [BCNT_W+3:0] got;
        logic [BCNT_W+3:0] exp;
        int ebc;
        forever begin
            @(negedge clk);
            ebc = m_act ? ((m_e < m_h) ? 0 : (m_e - m_h) / m_k) : m_hold;
            got = {start, doit, btu, done, bit_cnt};
            exp = {(m_act && (m_e < m_h)), m_act, m_btu(), m_done, BCNT_W'(ebc)};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL cycle t=%0t {start,doit,btu,done,bit_cnt} got=%b exp=%b", $time, got, exp);
            end
`ifdef RX_SYNC_EN
            n_vec++;
            if (rx_s !== m_h2) begin
                n_err++;
                $display("FAIL rx_s t=%0t got=%b exp=%b", $time, rx_s, m_h2);
            end
`endif
            if (reset) begin
                if (start)         cnt_st++;
                if (btu && !start) cnt_db++;
                if (done) begin
                    cnt_dn++;
                    done_bc = int'(bit_cnt);
                end
            end
        end
    endtask

    task automatic check(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; returns at the start of the cycle in which done is
    // expected (without synchronizer). fb[0] is the start bit.
    task automatic run_frame(input logic [11:0] fb, input int tog_e);
        int kk;
        int hh;
        int nn;
        int idx;
        kk = (baud_k < BAUD_W'(2)) ? 2 : int'(baud_k);
        hh = kk / 2;
        nn = 8 + int'(eight) + int'(pen);
        rx = fb[0];
        cyc(1);
        for (int e = 0; e < hh + nn * kk; e++) begin
            if (e == tog_e) eight = ~eight;
            idx = (e + 1) / kk;
            rx  = (idx < 12) ? fb[idx] : 1'b1;
            cyc(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] fb_8n1;
        logic [11:0] fb_7e1;
        logic [11:0] fb_8e1;
        int s0;
        int d0;
        int n0;
        fb_8n1 = {2'b11, 1'b1, 8'hA5, 1'b0};
        fb_7e1 = {2'b11, 1'b1, 1'b0, 7'h35, 1'b0};
        fb_8e1 = {1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};

        fork
            compare_loop();
        join_none

        cyc(3);
        check("reset_start", int'(start), 0);
        check("reset_doit", int'(doit), 0);
        check("reset_bitcnt", int'(bit_cnt), 0);
        reset = 1'b1;
        cyc(5);

        // 8N1, K=16
        eight = 1'b1; pen = 1'b0; baud_k = BAUD_W'(16);
        s0 = cnt_st; d0 = cnt_db; n0 = cnt_dn;
        run_frame(fb_8n1, -1);
        rx = 1'b1;
        cyc(6);
        check("8n1_start_cycles", cnt_st - s0, 8);
        check("8n1_data_btus", cnt_db - d0, 9);
        check("8n1_done_pulses", cnt_dn - n0, 1);
        check("8n1_bitcnt_at_done", done_bc, 9);

        // 7E1, K=10, eight toggled mid-frame
        eight = 1'b0; pen = 1'b1; baud_k = BAUD_W'(10);
        s0 = cnt_st; d0 = cnt_db; n0 = cnt_dn;
        run_frame(fb_7e1, 20);
        rx = 1'b1;
        cyc(6);
        check("7e1_start_cycles", cnt_st - s0, 5);
        check("7e1_data_btus", cnt_db - d0, 9);
        check("7e1_done_pulses", cnt_dn - n0, 1);
        check("7e1_bitcnt_at_done", done_bc, 9);

        // False start, K=16
        eight = 1'b1; pen = 1'b0; baud_k = BAUD_W'(16);
        s0 = cnt_st; d0 = cnt_db; n0 = cnt_dn;
        rx = 1'b0;
        cyc(3);
        rx = 1'b1;
        cyc(30);
        check("false_start_cycles", cnt_st - s0, 8);
        check("false_data_btus", cnt_db - d0, 0);
        check("false_done_pulses", cnt_dn - n0, 0);
        check("false_bitcnt", int'(bit_cnt), 0);

        // baud_k = 0 behaves as K=2
        baud_k = '0;
        s0 = cnt_st; d0 = cnt_db; n0 = cnt_dn;
        run_frame(fb_8n1, -1);
        rx = 1'b1;
        cyc(6);
        check("k0_start_cycles", cnt_st - s0, 1);
        check("k0_data_btus", cnt_db - d0, 9);
        check("k0_done_pulses", cnt_dn - n0, 1);

        // baud_k = 1, 8E1 back-to-back frames
        baud_k = BAUD_W'(1); pen = 1'b1;
        s0 = cnt_st; d0 = cnt_db; n0 = cnt_dn;
        run_frame(fb_8e1, -1);
        run_frame(fb_8e1, -1);
        rx = 1'b1;
        cyc(6);
        check("b2b_start_cycles", cnt_st - s0, 2);
        check("b2b_data_btus", cnt_db - d0, 20);
        check("b2b_done_pulses", cnt_dn - n0, 2);
        check("b2b_bitcnt_at_done", done_bc, 10);

        // Reset mid-frame during DATA
        baud_k = BAUD_W'(16); pen = 1'b0;
        rx = 1'b0;
        cyc(31);
        check("pre_reset_doit", int'(doit), 1);
        reset = 1'b0;
        #1;
        check("midrst_start", int'(start), 0);
        check("midrst_doit", int'(doit), 0);
        check("midrst_btu", int'(btu), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_bitcnt", int'(bit_cnt), 0);
        rx = 1'b1;
        cyc(3);
        reset = 1'b1;
        n0 = cnt_dn;
        cyc(40);
        check("post_reset_no_done", cnt_dn - n0, 0);
        check("post_reset_idle", int'(doit), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
